spi_frame_writer: RTL and testbench

//  Converts multi-lane SPI pixel packages plus SPI line/frame syncs into frame-buffer write strobes.

---
 rtl/spi_fb_pkg.sv | 26 ++
 rtl/sync_edge_detect.sv | 28 ++
 rtl/spi_frame_writer.sv | 172 +++++++++++++++++
 tb/tb_spi_frame_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_fb_pkg.sv
// Shared types and geometry helpers for the SPI-to-frame-buffer write path.
package spi_fb_pkg;

    localparam int unsigned DEF_PIX_WIDTH     = 8;
    localparam int unsigned DEF_LINES         = 4;
    localparam int unsigned DEF_HSIZE         = 640;
    localparam int unsigned DEF_VSIZE         = 360;
    localparam int unsigned DEF_DOUBLE_BUFFER = 1;

    localparam int unsigned FB_DEPTH = DEF_HSIZE * DEF_VSIZE;
    localparam int unsigned FB_AW    = $clog2((DEF_DOUBLE_BUFFER + 1) * FB_DEPTH);

    typedef logic [DEF_PIX_WIDTH-1:0] pixel_t;

    typedef enum logic {
        IDLE,
        EMIT
    } unpack_state_t;

    function automatic int unsigned fb_addr_width(input int unsigned db,
                                                  input int unsigned h,
                                                  input int unsigned v);
        return $clog2((db + 1) * h * v);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a 1-bit sync input once and flags rising/falling edges on the registered copy.
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sig_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic sig_q;
    logic prev_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_in;
            prev_q <= sig_q;
        end
    end

    assign level_out = sig_q;
    assign rise_out  = sig_q & ~prev_q;
    assign fall_out  = ~sig_q & prev_q;

endmodule

// File: rtl/spi_frame_writer.sv
// Unpacks multi-lane SPI pixel packages into single-pixel frame-buffer writes,
// tracking line/column position and an optional ping-pong bank.
module spi_frame_writer
    import spi_fb_pkg::*;
#(
    parameter int unsigned PIX_WIDTH     = DEF_PIX_WIDTH,
    parameter int unsigned LINES         = DEF_LINES,
    parameter int unsigned HSIZE         = DEF_HSIZE,
    parameter int unsigned VSIZE         = DEF_VSIZE,
    parameter int unsigned DOUBLE_BUFFER = DEF_DOUBLE_BUFFER,
    parameter int unsigned AW            = fb_addr_width(DOUBLE_BUFFER, HSIZE, VSIZE)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [LINES*PIX_WIDTH-1:0]   pkg_in,
    input  logic                         pkg_valid_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    output logic [AW-1:0]                addr_out,
    output logic [PIX_WIDTH-1:0]         pix_out,
    output logic                         we_out,
    output logic                         wr_bank_out,
    output logic                         rd_bank_out,
    output logic                         frame_done_out,
    output logic                         overflow_out
);

    localparam int unsigned XW  = $clog2(HSIZE + 1);
    localparam int unsigned YW  = $clog2(VSIZE + 1);
    localparam int unsigned BW  = $clog2(LINES + 1);
    localparam int unsigned PKW = LINES * PIX_WIDTH;

    localparam logic [XW-1:0] X_END      = XW'(HSIZE);
    localparam logic [YW-1:0] Y_END      = YW'(VSIZE);
    localparam logic [AW-1:0] ROW_STEP   = AW'(HSIZE);
    localparam logic [AW-1:0] BANK1_BASE = AW'(HSIZE * VSIZE);
    localparam logic [BW-1:0] BEATS_FULL = BW'(LINES);
    localparam logic [BW-1:0] ONE_BEAT   = BW'(1);

    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic unused_hs;

    sync_edge_detect u_hsync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sig_in    (hsync_in),
        .level_out (hs_lvl),
        .rise_out  (hs_rise),
        .fall_out  (hs_fall)
    );

    sync_edge_detect u_vsync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .sig_in    (vsync_in),
        .level_out (vs_lvl),
        .rise_out  (vs_rise),
        .fall_out  (vs_fall)
    );

    assign unused_hs = hs_lvl ^ hs_rise;

    unpack_state_t        state_q;
    logic [BW-1:0]        beats_q;
    logic [PKW-1:0]       shift_q;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic [AW-1:0]        row_base_q;
    logic [AW-1:0]        addr_q;
    logic [PIX_WIDTH-1:0] pix_q;
    logic                 we_q;
    logic                 bank_q;
    logic                 frame_done_q;
    logic                 overflow_q;

    logic [XW-1:0]        x_eff;
    logic [YW-1:0]        y_eff;
    logic [AW-1:0]        row_base_eff;
    logic [XW-1:0]        x_d;
    logic [AW-1:0]        bank_base;
    logic [PIX_WIDTH-1:0] beat_pix;
    logic                 accept;
    logic                 drop;
    logic                 more;
    logic                 emit;
    logic                 x_room;

    // Sync edges are folded into the coordinates before the beat is placed,
    // so a line end landing mid-package moves the remaining beats to the next row.
    always_comb begin
        x_eff        = x_q;
        y_eff        = y_q;
        row_base_eff = row_base_q;
        if (vs_rise) begin
            x_eff        = '0;
            y_eff        = '0;
            row_base_eff = '0;
        end else if (hs_fall && vs_lvl) begin
            x_eff = '0;
            if (y_q != Y_END) begin
                y_eff        = y_q + 1'b1;
                row_base_eff = row_base_q + ROW_STEP;
            end
        end

        accept   = pkg_valid_in && vs_lvl && (beats_q <= ONE_BEAT);
        drop     = pkg_valid_in && vs_lvl && (beats_q > ONE_BEAT);
        more     = (state_q == EMIT) && (beats_q > ONE_BEAT) && !vs_fall;
        emit     = accept || more;
        beat_pix = accept ? pkg_in[PIX_WIDTH-1:0] : shift_q[PIX_WIDTH-1:0];
        x_room   = (x_eff < X_END);
        x_d      = (emit && x_room) ? x_eff + 1'b1 : x_eff;
        bank_base = bank_q ? BANK1_BASE : '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            beats_q      <= '0;
            shift_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            addr_q       <= '0;
            pix_q        <= '0;
            we_q         <= 1'b0;
            bank_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_eff;
            row_base_q   <= row_base_eff;
            frame_done_q <= vs_fall;
            we_q         <= emit && x_room && (y_eff < Y_END);

            if (vs_fall && (DOUBLE_BUFFER != 0)) begin
                bank_q <= ~bank_q;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (emit) begin
                pix_q  <= beat_pix;
                addr_q <= bank_base + row_base_eff + AW'(x_eff);
            end

            // beats_q counts the beat currently on the outputs plus those still queued
            if (accept) begin
                state_q <= EMIT;
                beats_q <= BEATS_FULL;
                shift_q <= pkg_in >> PIX_WIDTH;
            end else if (more) begin
                beats_q <= beats_q - 1'b1;
                shift_q <= shift_q >> PIX_WIDTH;
            end else begin
                state_q <= IDLE;
                beats_q <= '0;
            end
        end
    end

    assign addr_out       = addr_q;
    assign pix_out        = pix_q;
    assign we_out         = we_q;
    assign wr_bank_out    = bank_q;
    assign rd_bank_out    = (DOUBLE_BUFFER != 0) ? ~bank_q : 1'b0;
    assign frame_done_out = frame_done_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// Scoreboard bench for spi_frame_writer: expected writes are queued as packages are driven.
module tb_spi_frame_writer;
    import spi_fb_pkg::*;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        pixel_t           pix;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst_in;
    logic [31:0]      pkg_in;
    logic             pkg_valid_in;
    logic             hsync_in;
    logic             vsync_in;
    logic [FB_AW-1:0] addr_out;
    logic [7:0]       pix_out;
    logic             we_out;
    logic             wr_bank_out;
    logic             rd_bank_out;
    logic             frame_done_out;
    logic             overflow_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wr_cnt   = 0;
    int unsigned fd_cnt   = 0;
    bit          sb_en    = 1'b1;
    wr_t         exp_q[$];

    int unsigned m_x    = 0;
    int unsigned m_y    = 0;
    int unsigned m_bank = 0;

    spi_frame_writer #(
        .PIX_WIDTH     (8),
        .LINES         (4),
        .HSIZE         (640),
        .VSIZE         (360),
        .DOUBLE_BUFFER (1)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .pkg_in         (pkg_in),
        .pkg_valid_in   (pkg_valid_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .addr_out       (addr_out),
        .pix_out        (pix_out),
        .we_out         (we_out),
        .wr_bank_out    (wr_bank_out),
        .rd_bank_out    (rd_bank_out),
        .frame_done_out (frame_done_out),
        .overflow_out   (overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    always @(negedge clk) begin
        if (frame_done_out) fd_cnt++;
        if (we_out) begin
            wr_t e;
            wr_cnt++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected_write", 32'(addr_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_addr", 32'(addr_out), 32'(e.addr));
                    check_eq("sb_pix", 32'(pix_out), 32'(e.pix));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_pkg(input int unsigned s);
        logic [31:0] r;
        for (int unsigned k = 0; k < 4; k++) r[k*8 +: 8] = 8'((s * 4 + k) * 7 + 3);
        return r;
    endfunction

    task automatic model_push(input logic [31:0] p);
        wr_t e;
        for (int unsigned k = 0; k < 4; k++) begin
            if (m_x < DEF_HSIZE && m_y < DEF_VSIZE) begin
                e.addr = FB_AW'(m_bank * FB_DEPTH + m_y * DEF_HSIZE + m_x);
                e.pix  = p[k*8 +: 8];
                exp_q.push_back(e);
            end
            if (m_x < DEF_HSIZE) m_x++;
        end
    endtask

    task automatic send_pkg(input logic [31:0] p);
        pkg_in       = p;
        pkg_valid_in = 1'b1;
        model_push(p);
        tick();
        pkg_valid_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_start();
        vsync_in = 1'b1;
        hsync_in = 1'b1;
        m_x = 0;
        m_y = 0;
        repeat (2) tick();
    endtask

    task automatic line_end();
        hsync_in = 1'b0;
        repeat (2) tick();
        hsync_in = 1'b1;
        tick();
        m_x = 0;
        if (m_y < DEF_VSIZE) m_y++;
    endtask

    task automatic frame_end();
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        m_bank   = m_bank ^ 1;
        repeat (2) tick();
        check_eq("frame_done_pulse", 32'(frame_done_out), 32'd1);
        check_eq("wr_bank_toggle", 32'(wr_bank_out), 32'(m_bank));
        check_eq("rd_bank_follow", 32'(rd_bank_out), 32'(m_bank ^ 1));
        tick();
        check_eq("frame_done_single", 32'(frame_done_out), 32'd0);
    endtask

    initial begin
        int unsigned c0;
        rst_in       = 1'b1;
        pkg_in       = '0;
        pkg_valid_in = 1'b0;
        hsync_in     = 1'b0;
        vsync_in     = 1'b0;
        repeat (3) tick();
        check_eq("rst_we", 32'(we_out), 32'd0);
        check_eq("rst_addr", 32'(addr_out), 32'd0);
        check_eq("rst_pix", 32'(pix_out), 32'd0);
        check_eq("rst_fd", 32'(frame_done_out), 32'd0);
        check_eq("rst_ovf", 32'(overflow_out), 32'd0);
        check_eq("rst_wr_bank", 32'(wr_bank_out), 32'd0);
        rst_in = 1'b0;
        tick();

        // Frame 0, bank 0: single package latency, overflow, overlong line
        frame_start();
        pkg_in       = 32'h4433_2211;
        pkg_valid_in = 1'b1;
        model_push(pkg_in);
        tick();
        pkg_valid_in = 1'b0;
        check_eq("t1_first_we", 32'(we_out), 32'd1);
        check_eq("t1_first_pix", 32'(pix_out), 32'h11);
        check_eq("t1_first_addr", 32'(addr_out), 32'd0);
        repeat (3) tick();
        check_eq("t1_last_we", 32'(we_out), 32'd1);
        check_eq("t1_last_pix", 32'(pix_out), 32'h44);
        check_eq("t1_last_addr", 32'(addr_out), 32'd3);
        tick();
        check_eq("t1_idle_we", 32'(we_out), 32'd0);
        check_eq("t1_no_ovf", 32'(overflow_out), 32'd0);

        pkg_in       = make_pkg(1);
        pkg_valid_in = 1'b1;
        model_push(pkg_in);
        tick();
        pkg_valid_in = 1'b0;
        tick();
        pkg_in       = make_pkg(2);
        pkg_valid_in = 1'b1;
        tick();
        pkg_valid_in = 1'b0;
        repeat (3) tick();
        check_eq("t3_overflow", 32'(overflow_out), 32'd1);

        line_end();
        c0 = wr_cnt;
        for (int unsigned i = 0; i < 170; i++) send_pkg(make_pkg(10 + i));
        tick();
        check_eq("t4_overlong_writes", wr_cnt - c0, 32'd640);
        frame_end();
        check_eq("fd_count_f0", fd_cnt, 32'd1);

        // Frame 1, bank 1: full line then line wrap
        frame_start();
        check_eq("f1_wr_bank", 32'(wr_bank_out), 32'd1);
        check_eq("f1_rd_bank", 32'(rd_bank_out), 32'd0);
        c0 = wr_cnt;
        for (int unsigned i = 0; i < 160; i++) send_pkg(make_pkg(300 + i));
        tick();
        check_eq("t2_line_writes", wr_cnt - c0, 32'd640);
        line_end();
        send_pkg(make_pkg(500));
        tick();
        check_eq("f1_rd_bank_mid", 32'(rd_bank_out), 32'd0);
        frame_end();
        check_eq("fd_count_f1", fd_cnt, 32'd2);

        // Frame 2: reset mid-package
        frame_start();
        sb_en        = 1'b0;
        pkg_in       = 32'hDDCC_BBAA;
        pkg_valid_in = 1'b1;
        tick();
        pkg_valid_in = 1'b0;
        check_eq("t6_beat0_pix", 32'(pix_out), 32'hAA);
        tick();
        check_eq("t6_beat1_pix", 32'(pix_out), 32'hBB);
        check_eq("t6_beat1_addr", 32'(addr_out), 32'd1);
        rst_in = 1'b1;
        #1;
        check_eq("t6_rst_we", 32'(we_out), 32'd0);
        check_eq("t6_rst_addr", 32'(addr_out), 32'd0);
        check_eq("t6_rst_pix", 32'(pix_out), 32'd0);
        check_eq("t6_rst_ovf", 32'(overflow_out), 32'd0);
        check_eq("t6_rst_bank", 32'(wr_bank_out), 32'd0);
        repeat (2) tick();
        rst_in = 1'b0;
        m_x    = 0;
        m_y    = 0;
        m_bank = 0;
        c0     = wr_cnt;
        repeat (6) tick();
        check_eq("t6_no_writes", wr_cnt - c0, 32'd0);
        sb_en = 1'b1;
        send_pkg(make_pkg(700));
        tick();
        check_eq("t6_post_writes", wr_cnt - c0, 32'd4);
        frame_end();
        check_eq("fd_count_f2", fd_cnt, 32'd3);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
